// File: rtl/fetch_arbiter_if.sv
// Bus bundle between the fetch arbiter and its environment: redirect input,
// load/store handshake, FIFO control and the single-ported RAM strobe.
interface fetch_arbiter_if #(
    parameter int A_WIDTH = 10
);
    logic               restart_i;
    logic [A_WIDTH-1:0] restart_addr_i;
    logic               ls_valid_i;
    logic               ls_store_i;
    logic [A_WIDTH-1:0] ls_addr_i;
    logic               ls_ready_o;
    logic               fifo_dequeue_i;
    logic               ram_en_o;
    logic               ram_we_o;
    logic [A_WIDTH-1:0] ram_addr_o;
    logic               fifo_enqueue_o;
    logic               fifo_clear_o;
    logic               load_data_valid_o;

    modport master (
        input  restart_i, restart_addr_i, ls_valid_i, ls_store_i, ls_addr_i, fifo_dequeue_i,
        output ls_ready_o, ram_en_o, ram_we_o, ram_addr_o, fifo_enqueue_o, fifo_clear_o,
               load_data_valid_o
    );

    modport slave (
        output restart_i, restart_addr_i, ls_valid_i, ls_store_i, ls_addr_i, fifo_dequeue_i,
        input  ls_ready_o, ram_en_o, ram_we_o, ram_addr_o, fifo_enqueue_o, fifo_clear_o,
               load_data_valid_o
    );
endinterface

// File: rtl/fetch_arbiter.sv
// Shares one RAM port between instruction prefetch into a FIFO and load/store
// traffic; restart redirects the fetch stream and flushes the FIFO.
module fetch_arbiter_chk (
    input logic clk,
    input logic reset_n,
    input logic en,
    input logic we,
    input logic enq,
    input logic ldv,
    input logic deq,
    input logic occ_zero
);
    // Run-time sanity checks on the RAM and FIFO side outputs
    always @(posedge clk) begin
        if (reset_n) begin
            if (deq && occ_zero) begin
                $warning("fetch_arbiter: dequeue with no outstanding fetch ignored");
            end
            assert (!(we && !en)) else $error("fetch_arbiter: write enable without RAM strobe");
            assert (!(enq && ldv)) else $error("fetch_arbiter: enqueue and load data in same cycle");
        end
    end
endmodule

module fetch_arbiter #(
    parameter int A_WIDTH = 10,
    parameter int DEPTH   = 8
) (
    input logic            clk,
    input logic            reset_n,
    fetch_arbiter_if.master bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [A_WIDTH-1:0] pc_r, pc_s;
    logic [A_WIDTH-1:0] addr_r, addr_s;
    logic [OCC_W-1:0]   occ_r, occ_s;
    logic en_r, en_s, we_r, we_s, clear_r, clear_s;
    logic enq_r, enq_s, ldv_r, ldv_s;
    logic fetch_cyc_r, fetch_cyc_s, load_cyc_r, load_cyc_s;
    logic ready_s, xfer_s, fetch_s, deq_ok_s;

    assign ready_s                = (state_r == RUN) && !bus.restart_i;
    assign bus.ls_ready_o         = ready_s;
    assign bus.ram_en_o           = en_r;
    assign bus.ram_we_o           = we_r;
    assign bus.ram_addr_o         = addr_r;
    assign bus.fifo_clear_o       = clear_r;
    assign bus.fifo_enqueue_o     = enq_r;
    assign bus.load_data_valid_o  = ldv_r;

    // Next-state, RAM request selection and occupancy bookkeeping
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        occ_s       = occ_r;
        en_s        = 1'b0;
        we_s        = 1'b0;
        addr_s      = {A_WIDTH{1'b0}};
        clear_s     = 1'b0;
        fetch_cyc_s = 1'b0;
        load_cyc_s  = 1'b0;
        deq_ok_s    = bus.fifo_dequeue_i && (occ_r != {OCC_W{1'b0}});
        xfer_s      = ready_s && bus.ls_valid_i;
        // The edge leaving FLUSH already issues the first fetch of the new stream
        fetch_s     = !bus.restart_i && !xfer_s && ((state_r == RUN) || (state_r == FLUSH))
                      && (occ_r < OCC_W'(DEPTH));
        // A fetch returning while the FIFO is being cleared is dropped
        enq_s       = fetch_cyc_r && !bus.restart_i;
        ldv_s       = load_cyc_r;

        case (state_r)
            IDLE:    state_s = IDLE;
            FLUSH:   state_s = RUN;
            RUN:     state_s = RUN;
            default: state_s = IDLE;
        endcase

        if (bus.restart_i) begin
            state_s = FLUSH;
            pc_s    = bus.restart_addr_i;
            occ_s   = {OCC_W{1'b0}};
            clear_s = 1'b1;
        end else begin
            if (xfer_s) begin
                en_s       = 1'b1;
                we_s       = bus.ls_store_i;
                addr_s     = bus.ls_addr_i;
                load_cyc_s = !bus.ls_store_i;
            end else if (fetch_s) begin
                en_s        = 1'b1;
                addr_s      = pc_r;
                pc_s        = pc_r + {{(A_WIDTH-1){1'b0}}, 1'b1};
                fetch_cyc_s = 1'b1;
            end else begin
                en_s = 1'b0;
            end
            occ_s = occ_r + {{(OCC_W-1){1'b0}}, fetch_s} - {{(OCC_W-1){1'b0}}, deq_ok_s};
        end
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            pc_r        <= {A_WIDTH{1'b0}};
            occ_r       <= {OCC_W{1'b0}};
            en_r        <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {A_WIDTH{1'b0}};
            clear_r     <= 1'b0;
            enq_r       <= 1'b0;
            ldv_r       <= 1'b0;
            fetch_cyc_r <= 1'b0;
            load_cyc_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            occ_r       <= occ_s;
            en_r        <= en_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            clear_r     <= clear_s;
            enq_r       <= enq_s;
            ldv_r       <= ldv_s;
            fetch_cyc_r <= fetch_cyc_s;
            load_cyc_r  <= load_cyc_s;
        end
    end

    fetch_arbiter_chk u_chk (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en_r),
        .we       (we_r),
        .enq      (enq_r),
        .ldv      (ldv_r),
        .deq      (bus.fifo_dequeue_i),
        .occ_zero (occ_r == {OCC_W{1'b0}})
    );
endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: expected per-cycle RAM/FIFO outputs are
// queued as each step is driven and checked after the following clock edge.
module tb_fetch_arbiter;
    typedef struct packed {
        logic       en;
        logic       we;
        logic [9:0] addr;
        logic       clr;
        logic       enq;
        logic       ldv;
    } out_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    out_t exp_q[$];

    fetch_arbiter_if #(.A_WIDTH(10)) bus ();

    fetch_arbiter #(.A_WIDTH(10), .DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic en, input logic we, input logic [9:0] addr,
                                input logic clr, input logic enq, input logic ldv);
        out_t o;
        o.en = en; o.we = we; o.addr = addr; o.clr = clr; o.enq = enq; o.ldv = ldv;
        return o;
    endfunction

    function automatic out_t fe(input logic [9:0] addr, input logic enq);
        return mk(1'b1, 1'b0, addr, 1'b0, enq, 1'b0);
    endfunction

    function automatic out_t sample();
        return mk(bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o, bus.fifo_clear_o,
                  bus.fifo_enqueue_o, bus.load_data_valid_o);
    endfunction

    task automatic check(input string tag, input out_t o, input out_t e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: got en=%b we=%b addr=%h clr=%b enq=%b ldv=%b, expected en=%b we=%b addr=%h clr=%b enq=%b ldv=%b",
                   tag, o.en, o.we, o.addr, o.clr, o.enq, o.ldv, e.en, e.we, e.addr, e.clr, e.enq, e.ldv);
        end
    endtask

    task automatic chk_ready(input string tag, input logic e);
        vectors++;
        assert (bus.ls_ready_o === e) else begin
            miscompares++;
            $error("FAIL %s: ls_ready_o got %b expected %b", tag, bus.ls_ready_o, e);
        end
    endtask

    task automatic drive(input logic rs, input logic [9:0] ra, input logic lv, input logic st,
                         input logic [9:0] la, input logic dq);
        bus.restart_i      = rs;
        bus.restart_addr_i = ra;
        bus.ls_valid_i     = lv;
        bus.ls_store_i     = st;
        bus.ls_addr_i      = la;
        bus.fifo_dequeue_i = dq;
    endtask

    task automatic edge_check(input out_t e, input string tag);
        out_t exp_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check(tag, sample(), exp_v);
    endtask

    task automatic tick(input logic rs, input logic [9:0] ra, input logic lv, input logic st,
                        input logic [9:0] la, input logic dq, input out_t e, input string tag);
        drive(rs, ra, lv, st, la, dq);
        edge_check(e, tag);
    endtask

    task automatic run(input out_t e, input string tag);
        tick(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, e, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        out_t z;
        z = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        vectors = 0;
        miscompares = 0;
        clk = 1'b0;
        reset_n = 1'b0;
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0);
        #2;
        check("reset", sample(), z);
        chk_ready("reset_ready", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // IDLE: no fetch, stray dequeue ignored
        run(z, "idle0");
        tick(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, z, "idle_deq");
        run(z, "idle1");
        chk_ready("idle_ready", 1'b0);

        // Restart to 0x040, fill FIFO with exactly DEPTH fetches
        tick(1'b1, 10'h040, 1'b0, 1'b0, 10'h000, 1'b0, mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0), "flush_a");
        for (int i = 0; i < 9; i++) begin
            run(mk(i < 8, 1'b0, (i < 8) ? (10'h040 + 10'(i)) : 10'h000, 1'b0, i > 0, 1'b0), "fill");
        end
        run(z, "full");
        tick(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, z, "deq_full");
        run(fe(10'h048, 1'b0), "refetch");
        run(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0), "refetch_enq");
        run(z, "full2");
        chk_ready("run_ready", 1'b1);

        // Load interleaved with fetch
        tick(1'b1, 10'h080, 1'b0, 1'b0, 10'h000, 1'b0, mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0), "flush_b");
        run(fe(10'h080, 1'b0), "fetch_b0");
        tick(1'b0, 10'h000, 1'b1, 1'b0, 10'h100, 1'b0, mk(1'b1, 1'b0, 10'h100, 1'b0, 1'b1, 1'b0), "load");
        run(mk(1'b1, 1'b0, 10'h081, 1'b0, 1'b0, 1'b1), "load_data");
        run(fe(10'h082, 1'b1), "fetch_b2");

        // Restart right after a fetch issue, with address wrap
        run(fe(10'h083, 1'b1), "fetch_b3");
        tick(1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 1'b0, mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0), "flush_c");
        run(fe(10'h3FE, 1'b0), "wrap0");
        run(fe(10'h3FF, 1'b1), "wrap1");
        run(fe(10'h000, 1'b1), "wrap2");
        run(fe(10'h001, 1'b1), "wrap3");

        // Store coincident with restart is held off and retried
        drive(1'b1, 10'h020, 1'b1, 1'b1, 10'h010, 1'b0);
        #1 chk_ready("st_rs_ready", 1'b0);
        edge_check(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0), "flush_d");
        drive(1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 1'b0);
        #1 chk_ready("st_flush_ready", 1'b0);
        edge_check(fe(10'h020, 1'b0), "fetch_d0");
        drive(1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 1'b0);
        #1 chk_ready("st_run_ready", 1'b1);
        edge_check(mk(1'b1, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0), "store");
        run(fe(10'h021, 1'b0), "fetch_d1");
        run(fe(10'h022, 1'b1), "fetch_d2");

        // Reset during a load's RAM cycle
        tick(1'b0, 10'h000, 1'b1, 1'b0, 10'h155, 1'b0, mk(1'b1, 1'b0, 10'h155, 1'b0, 1'b1, 1'b0), "load_e");
        #1 reset_n = 1'b0;
        #1 check("rst_mid", sample(), z);
        chk_ready("rst_mid_ready", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run(z, "post_rst0");
        run(z, "post_rst1");
        chk_ready("post_rst_ready", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter A_WIDTH, default 10, RAM word-address width.
REQ-002 Parameter DEPTH, default 8, instruction FIFO capacity in entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 restart_i  input  1  redirect request; sampled each rising edge.
REQ-006 restart_addr_i  input  A_WIDTH  new fetch address, valid with restart_i.
REQ-007 ls_valid_i  input  1  load/store request valid.
REQ-008 ls_store_i  input  1  1 = store, 0 = load; valid with ls_valid_i.
REQ-009 ls_addr_i  input  A_WIDTH  load/store word address; valid with ls_valid_i.
REQ-010 ls_ready_o  output  1  arbiter can accept a load/store this cycle.
REQ-011 fifo_dequeue_i  input  1  consumer popped one FIFO entry this cycle.
REQ-012 ram_en_o  output  1  registered RAM access strobe.
REQ-013 ram_we_o  output  1  registered RAM write enable.
REQ-014 ram_addr_o  output  A_WIDTH  registered RAM address.
REQ-015 fifo_enqueue_o  output  1  RAM read data is an instruction; push it into FIFO.
REQ-016 fifo_clear_o  output  1  flush FIFO.
REQ-017 load_data_valid_o  output  1  RAM read data is load return data.

Function
REQ-018 The FSM SHALL have states IDLE, FLUSH, RUN; IDLE after reset; no fetch issued in IDLE.
REQ-019 Any state, restart_i=1 at an edge -> FLUSH next cycle; pc <= restart_addr_i; occ <= 0.
REQ-020 FLUSH SHALL last exactly one cycle with fifo_clear_o=1 and ram_en_o=0, then go to RUN unless restart_i=1 again (stays FLUSH, reloads pc).
REQ-021 ls_ready_o SHALL be combinational: 1 iff state==RUN and restart_i==0.
REQ-022 A load/store transfers at an edge where ls_valid_i and ls_ready_o are both 1.
REQ-023 Priority at each RUN edge: restart > load/store transfer > fetch > no access.
REQ-024 Load/store transfer at edge E: cycle after E has ram_en_o=1, ram_addr_o=ls_addr_i, ram_we_o=ls_store_i.
REQ-025 Fetch at edge E only if occ<DEPTH: next cycle ram_en_o=1, ram_we_o=0, ram_addr_o=pc; pc <= pc+1 mod 2^A_WIDTH (wraps all-ones to 0).
REQ-026 occ (width clog2(DEPTH+1)) counts issued, not-yet-dequeued fetches: +1 on fetch, -1 on fifo_dequeue_i, unchanged when both occur.
REQ-027 fifo_dequeue_i with occ==0 SHALL be ignored (occ stays 0); simulation SHALL print a warning.
REQ-028 RAM read latency is one cycle: fifo_enqueue_o=1 the cycle after a fetch ram_en_o cycle, unless fifo_clear_o=1 in that cycle (fetch discarded).
REQ-029 load_data_valid_o=1 the cycle after a load ram_en_o cycle (two cycles after transfer edge); never for stores; not suppressed by restart.
REQ-030 A store already presented on the RAM port SHALL complete regardless of a concurrent restart.
REQ-031 ram_we_o SHALL never be 1 while ram_en_o is 0.
REQ-032 fifo_enqueue_o and load_data_valid_o SHALL never be 1 in the same cycle.

Reset
REQ-033 reset_n=0 SHALL immediately force state=IDLE, pc=0, occ=0 and all outputs 0 (ls_ready_o=0 via state).
REQ-034 Reset asserted mid-operation SHALL abandon in-flight accesses: no enqueue or load_data_valid_o after release.
REQ-035 After reset_n rises, the block stays IDLE until restart_i.

Verification
REQ-036 Reset, restart_i=1 addr 0x040 one cycle -> fifo_clear_o next cycle; ram_addr_o 0x040,0x041,... from cycle after; fifo_enqueue_o one cycle later each.
REQ-037 No dequeues, DEPTH=8 -> exactly 8 fetches (0x040-0x047), then ram_en_o=0; one fifo_dequeue_i -> exactly one more fetch 0x048.
REQ-038 Load at 0x100 while fetching -> one cycle ram_addr_o=0x100, ram_we_o=0, load_data_valid_o one cycle later, no enqueue that cycle; fetch resumes at the next pc, no address skipped.
REQ-039 restart_i (addr 0x3FE) in cycle after a fetch issue -> that fetch's enqueue suppressed, fifo_clear_o=1; fetches 0x3FE,0x3FF,0x000 (wrap).
REQ-040 Store at 0x010 coincident with restart_i -> ls_ready_o=0, no write; store held and retried -> write after FLUSH, in RUN.
REQ-041 reset_n pulsed low during a load's RAM cycle -> outputs 0 immediately, load_data_valid_o never asserted.
